// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan path.
package keypad_pkg;

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned N_COLS = 4;

  typedef enum logic {SCAN, HOLD} scan_state_t;

  typedef logic [3:0] onehot4_t;

  localparam onehot4_t ROW_IDLE = 4'b1111;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot4(input onehot4_t v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix pins plus the latched key outputs of the keypad scanner.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [N_COLS-1:0] cols_async;
  onehot4_t          rows;
  logic              key_pressed;
  onehot4_t          col_out;
  onehot4_t          row_out;

  modport master (
    input  cols_async,
    output rows,
    output key_pressed,
    output col_out,
    output row_out
  );

  modport slave (
    output cols_async,
    input  rows,
    input  key_pressed,
    input  col_out,
    input  row_out
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for an asynchronous bus, with a selectable reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: drives one row low at a time, latches a single
// clean press, and holds it until the columns stay idle for RELEASE_CYC cycles.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned RELEASE_CYC = 20
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  pins
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned REL_W = $clog2(RELEASE_CYC);
  localparam int unsigned ROW_W = $clog2(N_ROWS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);

  scan_state_t       state;
  logic [ROW_W-1:0]  row_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [REL_W-1:0]  rel_cnt;
  onehot4_t          col_lat;
  onehot4_t          row_lat;

  logic [N_COLS-1:0] cols_q;
  onehot4_t          cols_sync;
  onehot4_t          row_sel;
  logic              single_col;
  logic              cols_idle;
  logic              latched_hit;

  // Idle (all pulled up) reset value so nothing looks pressed out of reset.
  sync_2ff #(
    .WIDTH     (N_COLS),
    .RESET_VAL (ROW_IDLE)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pins.cols_async),
    .q     (cols_q)
  );

  always_comb begin
    cols_sync   = ~cols_q;
    row_sel     = onehot4_t'(1) << row_idx;
    single_col  = is_onehot4(cols_sync);
    cols_idle   = (cols_sync == '0);
    latched_hit = |(cols_sync & col_lat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= '0;
      div_cnt <= '0;
      rel_cnt <= '0;
      col_lat <= '0;
      row_lat <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (single_col) begin
              state   <= HOLD;
              col_lat <= cols_sync;
              row_lat <= row_sel;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Foreign columns alone neither extend nor restart the release count.
          if (cols_idle) begin
            if (rel_cnt == REL_LAST) begin
              state   <= SCAN;
              rel_cnt <= '0;
              div_cnt <= '0;
              row_idx <= row_idx + 1'b1;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
          end else if (latched_hit) begin
            rel_cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign pins.rows        = ROW_IDLE ^ row_sel;
  assign pins.key_pressed = (state == HOLD);
  assign pins.col_out     = col_lat;
  assign pins.row_out     = row_lat;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, RELEASE_CYC=8.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [3:0] rowpat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_DIV    (4),
    .RELEASE_CYC (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pins  (kp_if)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    kp_if.cols_async = 4'b1111;
    step(3);
    check("rst_rows", kp_if.rows, 4'b1110);
    check("rst_kp", {3'b0, kp_if.key_pressed}, 4'b0000);
    check("rst_col", kp_if.col_out, 4'b0000);
    check("rst_row", kp_if.row_out, 4'b0000);
    reset = 1'b0;

    // Idle scan: a new row every 4 cycles.
    for (int unsigned k = 0; k < 16; k++) begin
      check($sformatf("idle_rows_%0d", k), kp_if.rows, rowpat[k % 4]);
      check($sformatf("idle_kp_%0d", k), {3'b0, kp_if.key_pressed}, 4'b0000);
      step(4);
    end
    check("idle_col", kp_if.col_out, 4'b0000);

    // Press column 1 while row 2 is driven.
    step(8);
    check("p_rows_r2", kp_if.rows, 4'b1011);
    kp_if.cols_async = 4'b1101;
    step(3);
    check("p_kp_pre_eval", {3'b0, kp_if.key_pressed}, 4'b0000);
    step(1);
    check("p_kp", {3'b0, kp_if.key_pressed}, 4'b0001);
    check("p_col", kp_if.col_out, 4'b0010);
    check("p_row", kp_if.row_out, 4'b0100);
    check("p_rows_frozen", kp_if.rows, 4'b1011);

    // Release 5, re-press 3, release 10: drop lands 10 input cycles in.
    kp_if.cols_async = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      step(1);
      check($sformatf("gap_kp_%0d", k), {3'b0, kp_if.key_pressed}, 4'b0001);
    end
    kp_if.cols_async = 4'b1101;
    for (int unsigned k = 0; k < 3; k++) begin
      step(1);
      check($sformatf("rep_kp_%0d", k), {3'b0, kp_if.key_pressed}, 4'b0001);
    end
    kp_if.cols_async = 4'b1111;
    step(9);
    check("rel_kp_9", {3'b0, kp_if.key_pressed}, 4'b0001);
    check("rel_rows_9", kp_if.rows, 4'b1011);
    step(1);
    check("rel_kp_10", {3'b0, kp_if.key_pressed}, 4'b0000);
    check("rel_rows_10", kp_if.rows, 4'b0111);
    check("rel_col_kept", kp_if.col_out, 4'b0010);
    check("rel_row_kept", kp_if.row_out, 4'b0100);

    // Two columns on every row are rejected; scan keeps wrapping from row 3.
    kp_if.cols_async = 4'b1100;
    for (int unsigned k = 0; k < 8; k++) begin
      check($sformatf("dbl_rows_%0d", k), kp_if.rows, rowpat[(3 + k) % 4]);
      check($sformatf("dbl_kp_%0d", k), {3'b0, kp_if.key_pressed}, 4'b0000);
      step(4);
    end
    check("dbl_col_kept", kp_if.col_out, 4'b0010);
    kp_if.cols_async = 4'b1111;

    // Hold col 0 on row 0, then add col 3.
    step(4);
    check("c0_rows_r0", kp_if.rows, 4'b1110);
    kp_if.cols_async = 4'b1110;
    step(4);
    check("c0_kp", {3'b0, kp_if.key_pressed}, 4'b0001);
    check("c0_col", kp_if.col_out, 4'b0001);
    check("c0_row", kp_if.row_out, 4'b0001);
    kp_if.cols_async = 4'b0110;
    step(5);
    check("c03_kp", {3'b0, kp_if.key_pressed}, 4'b0001);
    check("c03_col", kp_if.col_out, 4'b0001);
    check("c03_rows", kp_if.rows, 4'b1110);

    // Reset mid-HOLD.
    reset = 1'b1;
    step(1);
    check("hrst_kp", {3'b0, kp_if.key_pressed}, 4'b0000);
    check("hrst_rows", kp_if.rows, 4'b1110);
    check("hrst_col", kp_if.col_out, 4'b0000);
    check("hrst_row", kp_if.row_out, 4'b0000);
    reset = 1'b0;
    kp_if.cols_async = 4'b1111;

    // Reset mid-SCAN restarts the divider.
    step(6);
    check("srst_pre", kp_if.rows, 4'b1101);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("srst_rows", kp_if.rows, 4'b1110);
    step(3);
    check("srst_rows_3", kp_if.rows, 4'b1110);
    step(1);
    check("srst_rows_4", kp_if.rows, 4'b1101);
    check("srst_kp", {3'b0, kp_if.key_pressed}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
